// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the MULT2 iterative multiplier (mul_unit).
//
// Contents:
//   MUL_F / MULH_F / MULHSU_F / MULHU_F : RV32M funct3 subset carried on 'func'
//   state_t                             : controller states IDLE / BUSY / DONE
//   MULDIV_FUNCT7                       : funct7 value the ALU-control decode
//                                         matches before raising 'start'
//
// Optional feature macro used by the files that import this package:
//   MUL_EARLY_TERM_EN (see mul_unit.sv)
// -----------------------------------------------------------------------------
package mul_pkg;

   // Product word / signedness selector, straight from funct3[1:0]
   localparam logic [1:0] MUL_F    = 2'b00;
   localparam logic [1:0] MULH_F   = 2'b01;
   localparam logic [1:0] MULHSU_F = 2'b10;
   localparam logic [1:0] MULHU_F  = 2'b11;

   // R-type funct7 that marks the M-extension multiply/divide group
   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mul_operand_cond.sv
// -----------------------------------------------------------------------------
// mul_operand_cond
// Combinational operand conditioner. Decides, from func, whether this operand
// is treated as signed, and returns its magnitude plus the sign bit that feeds
// the final negate decision. One instance for rs1, one for rs2.
//
// Parameters:
//   DATA_W    : operand width
//   OPERAND_B : 0 = rs1 conditioner, 1 = rs2 conditioner
//
// Ports:
//   func      in  [1:0]        RV32M funct3 subset (MUL/MULH/MULHSU/MULHU)
//   operand   in  [DATA_W-1:0] raw register value
//   magnitude out [DATA_W-1:0] |operand| (unsigned), or operand unchanged
//   sign      out              1 when the operand is signed and negative
//
// No configuration macros are used in this file.
// -----------------------------------------------------------------------------
module mul_operand_cond
   import mul_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter bit OPERAND_B = 1'b0
) (
   input  logic [1:0]        func,
   input  logic [DATA_W-1:0] operand,
   output logic [DATA_W-1:0] magnitude,
   output logic              sign
);

   logic is_signed;

   // rs1 is signed for everything but MULHU; rs2 only for MUL and MULH.
   // MUL's low word is the same either way, so it simply shares the signed
   // path. The magnitude of the most negative value still fits unsigned.
   always_comb begin
      if (OPERAND_B) begin
         is_signed = (func == MUL_F) || (func == MULH_F);
      end else begin
         is_signed = (func != MULHU_F);
      end
      sign      = is_signed & operand[DATA_W-1];
      magnitude = sign ? -operand : operand;
   end

endmodule

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
// Iterative radix-2 shift-add multiplier for the EX stage of the MULT2 datapath.
// Operands are converted to magnitudes, multiplied unsigned one bit per cycle,
// and the 2*DATA_W product is negated at the end when exactly one signed
// operand was negative. The pipeline is held with 'stall' while computing.
//
// Timing (default build): start edge -> DATA_W BUSY cycles -> 1 DONE cycle;
// result_valid rises on the edge that leaves DONE, i.e. DATA_W+1 edges after
// the start edge. stall is high from the start cycle to the last BUSY cycle.
//
// Configuration macro:
//   MUL_EARLY_TERM_EN : when defined, BUSY finishes as soon as the remaining
//                       multiplier bits are zero, shifting the outstanding
//                       distance in one step. Results are unchanged.
//
// Parameters:
//   DATA_W : operand/result width
//   CNT_W  : iteration counter width, 2**CNT_W > DATA_W
//
// Ports:
//   clk          in               rising-edge clock
//   arst         in               asynchronous active-high reset
//   start        in               MUL-class instruction in EX (used in IDLE)
//   func         in  [1:0]        00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   op_a         in  [DATA_W-1:0] rs1 value
//   op_b         in  [DATA_W-1:0] rs2 value
//   flush        in               pipeline flush, aborts any operation
//   stall        out              freezes PC, IF/ID, ID/EX
//   result       out [DATA_W-1:0] selected product word, held until next DONE
//   result_valid out              one-cycle strobe for EX/MEM capture
// -----------------------------------------------------------------------------
module mul_unit
   import mul_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              start,
   input  logic [1:0]        func,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   output logic              stall,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   state_t              state;
   logic [CNT_W-1:0]    counter;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   mplier;
   logic [DATA_W-1:0]   mcand;
   logic [1:0]          func_q;
   logic                neg_flag;

   logic [DATA_W-1:0]   mag_a;
   logic [DATA_W-1:0]   mag_b;
   logic                sign_a;
   logic                sign_b;

   logic [DATA_W:0]     sum;
   logic [2*DATA_W-1:0] shifted;
   logic [2*DATA_W-1:0] step;
   logic                last_iter;
   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   sel_word;

`ifdef MUL_EARLY_TERM_EN
   logic [DATA_W-1:0]   remaining;
   logic [CNT_W-1:0]    extra;
`endif

   // Magnitude/sign extraction for both operands
   mul_operand_cond #(
      .DATA_W    (DATA_W),
      .OPERAND_B (1'b0)
   ) u_cond_a (
      .func      (func),
      .operand   (op_a),
      .magnitude (mag_a),
      .sign      (sign_a)
   );

   mul_operand_cond #(
      .DATA_W    (DATA_W),
      .OPERAND_B (1'b1)
   ) u_cond_b (
      .func      (func),
      .operand   (op_b),
      .magnitude (mag_b),
      .sign      (sign_b)
   );

   // One shift-add iteration. The add is DATA_W+1 bits wide so its carry
   // becomes the new accumulator MSB once {carry, acc, mplier} shifts right.
   // As the multiplier is consumed, product low bits fill mplier from the top.
   always_comb begin
      sum     = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
      shifted = {sum, mplier[DATA_W-1:1]};
`ifdef MUL_EARLY_TERM_EN
      // Only the low DATA_W-counter bits of mplier are still multiplier bits;
      // the rest are product bits. If nothing beyond the current bit is left,
      // finish this iteration and do all outstanding shifts at once.
      remaining = (mplier >> 1) & ({DATA_W{1'b1}} >> (counter + CNT_W'(1)));
      extra     = LAST_CNT - counter;
      if (remaining == '0) begin
         step      = shifted >> extra;
         last_iter = 1'b1;
      end else begin
         step      = shifted;
         last_iter = (counter == LAST_CNT);
      end
`else
      step      = shifted;
      last_iter = (counter == LAST_CNT);
`endif
   end

   // Sign fix-up and word select, used when leaving DONE
   always_comb begin
      prod     = {acc, mplier};
      prod_fix = neg_flag ? -prod : prod;
      sel_word = (func_q == MUL_F) ? prod_fix[DATA_W-1:0]
                                   : prod_fix[2*DATA_W-1:DATA_W];
   end

   // Stall must drop in the very cycle a flush arrives, so it is decoded
   // from the current state and inputs rather than registered.
   always_comb begin
      case (state)
         IDLE:    stall = start & ~flush;
         BUSY:    stall = ~flush;
         default: stall = 1'b0;
      endcase
   end

   // Controller and datapath registers. result_valid defaults low every cycle
   // so it can only ever be a single-cycle strobe on the DONE -> IDLE edge.
   // flush wins over everything; a flushed op never touches result.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state        <= IDLE;
         counter      <= '0;
         acc          <= '0;
         mplier       <= '0;
         mcand        <= '0;
         func_q       <= MUL_F;
         neg_flag     <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  mcand    <= mag_a;
                  mplier   <= mag_b;
                  func_q   <= func;
                  neg_flag <= sign_a ^ sign_b;
                  counter  <= '0;
                  acc      <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  acc     <= step[2*DATA_W-1:DATA_W];
                  mplier  <= step[DATA_W-1:0];
                  counter <= counter + CNT_W'(1);
                  if (last_iter) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (!flush) begin
                  result       <= sel_word;
                  result_valid <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
